operand_dispatch: RTL and testbench

- Parametrised, registered successor to the 1x4 rs1 operand demux.
- Routes an rs1/rs2 operand pair to one of N_CH functional-unit channels selected by an opcode field.
- Each channel has a one-entry output register with a valid/ready handshake, so a stalled unit never loses or corrupts operands.
- Sits between register-file read and the ALU units (add/sub/mul/div, extensible).

---
 rtl/operand_dispatch_if.sv | 27 ++
 rtl/operand_dispatch.sv | 91 +++++++++
 tb/tb_operand_dispatch.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_dispatch_if.sv
// rtl/operand_dispatch_if.sv - operand pair input stream and per-channel output bundle
interface operand_dispatch_if #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic [DATA_W-1:0]      in_rs1;
  logic [DATA_W-1:0]      in_rs2;
  logic [N_CH-1:0]        out_valid;
  logic [N_CH-1:0]        out_ready;
  logic [N_CH*DATA_W-1:0] out_rs1;
  logic [N_CH*DATA_W-1:0] out_rs2;

  // master = register-file / functional-unit side, slave = the dispatcher
  modport master (
    output in_valid, in_sel, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2
  );

  modport slave (
    input  in_valid, in_sel, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2
  );
endinterface

// File: rtl/operand_dispatch.sv
// rtl/operand_dispatch.sv - routes rs1/rs2 pairs to N_CH one-entry registered channels
module operand_dispatch #(
  parameter int DATA_W    = 16,
  parameter int N_CH      = 4,
  parameter int SEL_W     = 2,
  parameter int ZERO_IDLE = 1,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  operand_dispatch_if.slave  bus,
  output logic               sel_err,
  output logic [CNT_W-1:0]   disp_count
);
  localparam int PAD_W = 2 ** SEL_W;

  logic [N_CH-1:0]   valid_q, valid_d;
  logic [DATA_W-1:0] rs1_q [N_CH];
  logic [DATA_W-1:0] rs1_d [N_CH];
  logic [DATA_W-1:0] rs2_q [N_CH];
  logic [DATA_W-1:0] rs2_d [N_CH];
  logic              sel_err_q, sel_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PAD_W-1:0]  valid_pad;
  logic [PAD_W-1:0]  ready_pad;
  logic              sel_legal;
  logic              accept;

  // Padding to the full select range keeps illegal selects from indexing past the channels.
  always_comb begin
    valid_pad    = PAD_W'(valid_q);
    ready_pad    = PAD_W'(bus.out_ready);
    sel_legal    = (32'(bus.in_sel) < N_CH);
    bus.in_ready = sel_legal ? (!valid_pad[bus.in_sel] || ready_pad[bus.in_sel]) : 1'b1;
    accept       = bus.in_valid && bus.in_ready;
  end

  always_comb begin
    valid_d   = valid_q & ~bus.out_ready;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    cnt_d     = cnt_q;
    sel_err_d = accept && !sel_legal;
    for (int k = 0; k < N_CH; k++) begin
      // A reload wins over a same-cycle drain, giving one pair per cycle per channel.
      if (accept && sel_legal && (bus.in_sel == SEL_W'(k))) begin
        valid_d[k] = 1'b1;
        rs1_d[k]   = bus.in_rs1;
        rs2_d[k]   = bus.in_rs2;
      end
    end
    if (accept && sel_legal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      sel_err_q <= 1'b0;
      cnt_q     <= '0;
      for (int k = 0; k < N_CH; k++) begin
        rs1_q[k] <= '0;
        rs2_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      sel_err_q <= sel_err_d;
      cnt_q     <= cnt_d;
      for (int k = 0; k < N_CH; k++) begin
        rs1_q[k] <= rs1_d[k];
        rs2_q[k] <= rs2_d[k];
      end
    end
  end

  always_comb begin
    bus.out_valid = valid_q;
    bus.out_rs1   = '0;
    bus.out_rs2   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if ((ZERO_IDLE == 0) || valid_q[k]) begin
        bus.out_rs1[k*DATA_W +: DATA_W] = rs1_q[k];
        bus.out_rs2[k*DATA_W +: DATA_W] = rs2_q[k];
      end
    end
    sel_err    = sel_err_q;
    disp_count = cnt_q;
  end
endmodule

// File: tb/tb_operand_dispatch.sv
// tb/tb_operand_dispatch.sv - scoreboard bench for operand_dispatch (default and 3-channel builds)
module tb_operand_dispatch;
  logic clk;
  logic rst;

  operand_dispatch_if #(.DATA_W(16), .N_CH(4), .SEL_W(2)) ifa ();
  operand_dispatch_if #(.DATA_W(16), .N_CH(3), .SEL_W(2)) ifb ();

  logic       sel_err_a, sel_err_b;
  logic [7:0] disp_a;
  logic [3:0] disp_b;

  operand_dispatch #(.DATA_W(16), .N_CH(4), .SEL_W(2), .ZERO_IDLE(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .sel_err(sel_err_a), .disp_count(disp_a)
  );

  operand_dispatch #(.DATA_W(16), .N_CH(3), .SEL_W(2), .ZERO_IDLE(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .sel_err(sel_err_b), .disp_count(disp_b)
  );

  typedef struct {
    int          ch;
    logic [15:0] rs1;
    logic [15:0] rs2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mon_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [15:0] r1, input logic [15:0] r2);
    exp_t e;
    e.ch  = ch;
    e.rs1 = r1;
    e.rs2 = r2;
    sb.push_back(e);
  endtask

  // Monitor: each completed channel handshake on dut_a must match the oldest expected pair for that channel.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (ifa.out_valid[k] && ifa.out_ready[k]) begin
          mon_idx = -1;
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].ch == k) begin
              mon_idx = i;
              break;
            end
          end
          if (mon_idx < 0) begin
            chk("sb_unexpected_ch", 64'(k), 64'hFF);
          end else begin
            chk("sb_rs1", 64'(ifa.out_rs1[k*16 +: 16]), 64'(sb[mon_idx].rs1));
            chk("sb_rs2", 64'(ifa.out_rs2[k*16 +: 16]), 64'(sb[mon_idx].rs2));
            sb.delete(mon_idx);
          end
        end
      end
    end
  end

  task automatic send_a(input logic [1:0] sel, input logic [15:0] r1, input logic [15:0] r2);
    int n;
    n = 0;
    ifa.in_valid = 1'b1;
    ifa.in_sel   = sel;
    ifa.in_rs1   = r1;
    ifa.in_rs2   = r2;
    @(negedge clk);
    while (!ifa.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_in_ready", 64'(ifa.in_ready), 64'd1);
    push(int'(sel), r1, r2);
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_sel = '0; ifa.in_rs1 = '0; ifa.in_rs2 = '0; ifa.out_ready = '0;
    ifb.in_valid = 1'b0; ifb.in_sel = '0; ifb.in_rs1 = '0; ifb.in_rs2 = '0; ifb.out_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_a", 64'(ifa.out_valid), 64'd0);
    chk("rst_rs1_a", 64'(ifa.out_rs1), 64'd0);
    chk("rst_disp_a", 64'(disp_a), 64'd0);
    chk("rst_selerr_a", 64'(sel_err_a), 64'd0);
    rst = 1'b0;

    // basic routing to channel 1
    send_a(2'd1, 16'hAAAA, 16'h5555);
    chk("basic_valid", 64'(ifa.out_valid), 64'h2);
    chk("basic_rs1", 64'(ifa.out_rs1), 64'h0000_0000_AAAA_0000);
    chk("basic_rs2", 64'(ifa.out_rs2), 64'h0000_0000_5555_0000);
    chk("basic_disp", 64'(disp_a), 64'd1);
    ifa.out_ready = 4'b0010;
    @(posedge clk); #1;
    ifa.out_ready = 4'b0000;
    chk("basic_drained", 64'(ifa.out_valid), 64'h0);
    chk("basic_idle_zero", 64'(ifa.out_rs1), 64'h0);

    // backpressure on channel 3, then drain and reload in one cycle
    send_a(2'd3, 16'h3333, 16'h1111);
    ifa.in_valid = 1'b1; ifa.in_sel = 2'd3; ifa.in_rs1 = 16'h4444; ifa.in_rs2 = 16'h2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(ifa.in_ready), 64'd0);
      chk("bp_hold_rs1", 64'(ifa.out_rs1[63:48]), 64'h3333);
      @(posedge clk); #1;
    end
    ifa.out_ready = 4'b1000;
    @(negedge clk);
    chk("bp_release_ready", 64'(ifa.in_ready), 64'd1);
    push(3, 16'h4444, 16'h2222);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.out_ready = 4'b0000;
    chk("bp_reload_valid", 64'(ifa.out_valid), 64'h8);
    chk("bp_reload_rs1", 64'(ifa.out_rs1[63:48]), 64'h4444);
    ifa.out_ready = 4'b1000;
    @(posedge clk); #1;
    ifa.out_ready = 4'b0000;
    chk("bp_disp", 64'(disp_a), 64'd3);

    // streaming 8 pairs to channel 0
    ifa.out_ready = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      ifa.in_valid = 1'b1; ifa.in_sel = 2'd0;
      ifa.in_rs1 = 16'h1000 + 16'(i); ifa.in_rs2 = 16'h2000 + 16'(i);
      @(negedge clk);
      chk("stream_in_ready", 64'(ifa.in_ready), 64'd1);
      push(0, 16'h1000 + 16'(i), 16'h2000 + 16'(i));
      @(posedge clk); #1;
    end
    ifa.in_valid = 1'b0;
    @(posedge clk); #1;
    ifa.out_ready = 4'b0000;
    chk("stream_disp", 64'(disp_a), 64'd11);
    chk("stream_empty", 64'(ifa.out_valid), 64'h0);

    // drain channel 2 while loading channel 1
    send_a(2'd2, 16'h2222, 16'h2223);
    ifa.out_ready = 4'b0100;
    ifa.in_valid = 1'b1; ifa.in_sel = 2'd1; ifa.in_rs1 = 16'hBEEF; ifa.in_rs2 = 16'hCAFE;
    @(negedge clk);
    chk("indep_in_ready", 64'(ifa.in_ready), 64'd1);
    push(1, 16'hBEEF, 16'hCAFE);
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
    ifa.out_ready = 4'b0000;
    chk("indep_valid", 64'(ifa.out_valid), 64'h2);
    chk("indep_rs2", 64'(ifa.out_rs2[31:16]), 64'hCAFE);
    ifa.out_ready = 4'b0010;
    @(posedge clk); #1;
    ifa.out_ready = 4'b0000;

    // asynchronous reset while channel 2 is full
    send_a(2'd2, 16'h1234, 16'h4321);
    chk("pre_rst_rs1", 64'(ifa.out_rs1), 64'h0000_1234_0000_0000);
    chk("pre_rst_disp", 64'(disp_a), 64'd14);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_valid", 64'(ifa.out_valid), 64'h0);
    chk("arst_rs1", 64'(ifa.out_rs1), 64'h0);
    chk("arst_disp", 64'(disp_a), 64'd0);
    chk("arst_selerr", 64'(sel_err_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // dut_b: N_CH=3, ZERO_IDLE=0, CNT_W=4
    chk("b_idle_rs1", 64'(ifb.out_rs1), 64'h0);
    ifb.in_valid = 1'b1; ifb.in_sel = 2'd3; ifb.in_rs1 = 16'hDEAD; ifb.in_rs2 = 16'hBEEF;
    @(negedge clk);
    chk("ill_in_ready", 64'(ifb.in_ready), 64'd1);
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    chk("ill_selerr", 64'(sel_err_b), 64'd1);
    chk("ill_valid", 64'(ifb.out_valid), 64'h0);
    chk("ill_disp", 64'(disp_b), 64'd0);
    @(posedge clk); #1;
    chk("ill_pulse_end", 64'(sel_err_b), 64'd0);
    ifb.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("ill_b2b_1", 64'(sel_err_b), 64'd1);
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    chk("ill_b2b_2", 64'(sel_err_b), 64'd1);
    @(posedge clk); #1;
    chk("ill_b2b_end", 64'(sel_err_b), 64'd0);

    // hold last value after drain
    ifb.in_valid = 1'b1; ifb.in_sel = 2'd0; ifb.in_rs1 = 16'h7777; ifb.in_rs2 = 16'h8888;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    chk("hold_valid", 64'(ifb.out_valid), 64'h1);
    chk("hold_disp", 64'(disp_b), 64'd1);
    ifb.out_ready = 3'b001;
    @(posedge clk); #1;
    ifb.out_ready = 3'b000;
    chk("hold_drained", 64'(ifb.out_valid), 64'h0);
    chk("hold_rs1", 64'(ifb.out_rs1[15:0]), 64'h7777);
    chk("hold_rs2", 64'(ifb.out_rs2[15:0]), 64'h8888);

    // saturation: 20 more legal dispatches on a 4-bit counter
    ifb.out_ready = 3'b010;
    ifb.in_valid = 1'b1; ifb.in_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      ifb.in_rs1 = 16'(i); ifb.in_rs2 = 16'(100 + i);
      @(negedge clk);
      if (i == 19) chk("sat_in_ready", 64'(ifb.in_ready), 64'd1);
      @(posedge clk); #1;
    end
    ifb.in_valid = 1'b0;
    chk("sat_disp", 64'(disp_b), 64'd15);
    @(posedge clk); #1;
    ifb.out_ready = 3'b000;
    chk("sat_drained", 64'(ifb.out_valid), 64'h0);
    chk("sat_hold_rs1", 64'(ifb.out_rs1[31:16]), 64'd19);
    chk("sat_disp_stable", 64'(disp_b), 64'd15);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
